fetch_bundle_pipe: RTL
======================

// Module: fetch_bundle_pipe
// PURPOSE
//  Parametrised elastic delay pipeline for multi-lane fetch bundles between fetch and decode.
//  Carries DEPTH registered stages of LANES-wide packets with per-lane valids.
//  Uses a valid/ready handshake with bubble collapse, and squashes all stages on a retire mispredict flush.
//  Replaces fixed two-stage, all-lanes-ready delay logic; usable in RTL and as a bench-side model.
// PARAMETERS
//  LANES  4   fetch lanes per bundle (MACHINE_WIDTH)
//  PKT_W  64  bits per lane packet (width of FETCH_PACKET)
//  DEPTH  2   pipeline stages, >=1
//  CNT_W  32  perf counter width (FETCH_PIPE_PERF_EN only)
// PORTS
//  clk          in   1                    clock, all state on posedge
//  rst_n        in   1                    asynchronous, active-low reset
//  flush_i      in   1                    retire mispredict: squash every stage
//  in_valid_i   in   LANES                per-lane valid of incoming bundle
//  in_pkt_i     in   LANES*PKT_W          incoming lane packets, lane 0 at LSBs
//  in_ready_o   out  1                    pipe accepts a bundle this cycle
//  out_valid_o  out  LANES                per-lane valid of head bundle
//  out_pkt_o    out  LANES*PKT_W          head bundle packets
//  out_ready_i  in   1                    consumer takes head bundle (whole bundle)
//  occupancy_o  out  $clog2(DEPTH+1)      number of occupied stages
//  stall_cnt_o  out  CNT_W                [PERF] cycles head valid & ~out_ready_i
//  flush_cnt_o  out  CNT_W                [PERF] flush_i cycles that killed >=1 bundle
// BEHAVIOUR
//  - Reset: all stage valids, lane valids and payloads = 0.
//    in_ready_o=1, out_valid_o=0, out_pkt_o=0, occupancy_o=0, perf counters=0.
//  - Stage k occupied (svld[k]) iff its stored lane-valid vector is nonzero. Stage DEPTH-1 is the head.
//  - Advance: adv[DEPTH-1] = svld[DEPTH-1] & out_ready_i.
//    adv[k] = svld[k] & (~svld[k+1] | adv[k+1]).
//  - in_ready_o = ~flush_i & (~svld[0] | adv[0]); purely combinational, no reg-to-ready loop through the input.
//  - Accept = in_ready_o & |in_valid_i. An all-zero in_valid_i is never stored; no bubble is written.
//  - Bubble collapse: a bundle moves into an empty downstream stage even when the head is stalled.
//  - Minimum latency DEPTH cycles, input to out_valid_o. Throughput 1 bundle/cycle when out_ready_i=1.
//  - Ordering is strict FIFO. No lane reordering. Lane valids travel with their payload unchanged.
//  - out_valid_o = head lane valids & {LANES{~flush_i}}. out_pkt_o = head payload.
//  - Flush: every stage's valids and payloads are zeroed at the next edge, and occupancy goes to 0.
//    Flush overrides accept and advance in the same cycle: the input is dropped and the head is not handed off.
//  - Stalled head (out_ready_i=0): head contents stay stable; upstream stages fill until full; then in_ready_o=0.
//  - Full pipe with out_ready_i=1: in_ready_o=1. Accept and retire happen in the same cycle; occupancy is unchanged.
//  - occupancy_o = popcount(svld), registered, updated in the same edge as svld.
//  - Reset mid-operation: immediate asynchronous clear to the reset values; in-flight bundles are lost.
// CONFIGURATION
//  FETCH_PIPE_PERF_EN defined:
//  - stall_cnt_o and flush_cnt_o are present and count with saturation at 2^CNT_W-1.
//  - Both counters clear on reset only, not on flush.
//  FETCH_PIPE_PERF_EN undefined:
//  - both ports and counters are absent; core behaviour is identical.
// STRUCTURE
//  fetch_pipe_pkg:
//  - FETCH_PACKET typedef, FETCH_LANES default, function popcount_occ().
//  fetch_pipe_stage sub-module:
//  - one stage register holding lane valids and payload, with inputs load, clear and flush.
//  - instantiated DEPTH times by generate. Top level holds the advance/ready chain, occupancy and perf counters.
// TESTING
//  1. Reset, then one bundle with in_valid_i=4'b1111 and out_ready_i=1 (DEPTH=2):
//     out_valid_o=4'b1111 two cycles later, payload matches, occupancy_o returns to 0.
//  2. out_ready_i=0, push 3 bundles into DEPTH=2:
//     in_ready_o drops after 2 accepts, the 3rd is held at the source, occupancy_o=2.
//     Release: bundles emerge in order, one per cycle.
//  3. Partial lanes in_valid_i=4'b0011:
//     out_valid_o=4'b0011 and lanes 2-3 are not presented.
//     in_valid_i=0: no accept, occupancy_o stays 0.
//  4. Full pipe, then flush_i with in_valid_i=4'b1111 in the same cycle:
//     out_valid_o=0 that cycle, and the next cycle occupancy_o=0 with all outputs zero.
//     With PERF enabled, flush_cnt_o increments by 1.
//  5. Head stalled, stage 0 empty, new bundle in:
//     the bundle collapses into stage 1 only when stage 1 is empty, and the head payload stays unchanged.
//  6. Assert rst_n low mid-stream with 2 bundles in flight:
//     outputs reach reset values asynchronously, and nothing is emitted after release.

Source files
------------

// File: rtl/fetch_pipe_pkg.sv
// Shared types and helpers for the fetch-to-decode bundle pipeline.
// FETCH_PIPE_PERF_EN (top level) enables the stall and flush counters.
package fetch_pipe_pkg;

    localparam int FETCH_LANES = 4;
    localparam int FETCH_PKT_W = 64;

    typedef logic [FETCH_PKT_W-1:0] FETCH_PACKET;

    // Counts occupied stages; pipelines deeper than 32 stages are not supported.
    function automatic int popcount_occ(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_pipe_stage.sv
// One bundle stage of the fetch pipe: lane valids plus payload.
// Flush beats load, and load beats clear, so a stage refilled in its emptying cycle keeps the new bundle.
module fetch_pipe_stage #(
    parameter int LANES = 4,
    parameter int PKT_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic                   i_flush,
    input  logic [LANES-1:0]       i_vld,
    input  logic [LANES*PKT_W-1:0] i_pkt,
    output logic [LANES-1:0]       o_vld,
    output logic [LANES*PKT_W-1:0] o_pkt
);

    logic [LANES-1:0]       r_vld;
    logic [LANES*PKT_W-1:0] r_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_pkt <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
            r_pkt <= '0;
        end else if (i_load) begin
            r_vld <= i_vld;
            r_pkt <= i_pkt;
        end else if (i_clear) begin
            r_vld <= '0;
            r_pkt <= '0;
        end
    end

    assign o_vld = r_vld;
    assign o_pkt = r_pkt;

endmodule

// File: rtl/fetch_bundle_pipe.sv
// Elastic DEPTH-stage fetch bundle pipe with bubble collapse and mispredict flush.
// Define FETCH_PIPE_PERF_EN to add the saturating stall/flush perf counters.
module fetch_bundle_pipe
    import fetch_pipe_pkg::*;
#(
    parameter int LANES = FETCH_LANES,
    parameter int PKT_W = FETCH_PKT_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic [LANES-1:0]           in_valid_i,
    input  logic [LANES*PKT_W-1:0]     in_pkt_i,
    output logic                       in_ready_o,
    output logic [LANES-1:0]           out_valid_o,
    output logic [LANES*PKT_W-1:0]     out_pkt_o,
    input  logic                       out_ready_i,
`ifdef FETCH_PIPE_PERF_EN
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int BUN_W = LANES * PKT_W;

    logic [LANES-1:0] w_svlv [DEPTH];
    logic [BUN_W-1:0] w_spkt [DEPTH];
    logic [DEPTH-1:0] w_svld;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    logic [DEPTH-1:0] w_nvld;
    logic [31:0]      w_nvld32;
    logic             w_ready;
    logic             w_nxt;
    logic [OCC_W-1:0] r_occ;

    // Advance chain walks from the head backwards; it never looks at in_valid_i.
    always_comb begin
        w_svld   = '0;
        w_adv    = '0;
        w_load   = '0;
        w_clear  = '0;
        w_nvld   = '0;
        w_nvld32 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_svld[k] = |w_svlv[k];
        end
        w_nxt = w_svld[DEPTH-1] & out_ready_i;
        w_adv[DEPTH-1] = w_nxt;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_nxt    = w_svld[k] & (~w_svld[k+1] | w_nxt);
            w_adv[k] = w_nxt;
        end
        w_ready   = ~flush_i & (~w_svld[0] | w_adv[0]);
        w_load[0] = w_ready & (|in_valid_i);
        for (int k = 1; k < DEPTH; k++) begin
            w_load[k] = w_adv[k-1] & ~flush_i;
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_clear[k] = w_adv[k] & ~w_load[k];
            if (flush_i)         w_nvld[k] = 1'b0;
            else if (w_load[k])  w_nvld[k] = 1'b1;
            else if (w_clear[k]) w_nvld[k] = 1'b0;
            else                 w_nvld[k] = w_svld[k];
        end
        w_nvld32[DEPTH-1:0] = w_nvld;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [LANES-1:0] w_vin;
        logic [BUN_W-1:0] w_pin;
        if (g == 0) begin : g_first
            assign w_vin = in_valid_i;
            assign w_pin = in_pkt_i;
        end else begin : g_next
            assign w_vin = w_svlv[g-1];
            assign w_pin = w_spkt[g-1];
        end
        fetch_pipe_stage #(.LANES(LANES), .PKT_W(PKT_W)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_clear (w_clear[g]),
            .i_flush (flush_i),
            .i_vld   (w_vin),
            .i_pkt   (w_pin),
            .o_vld   (w_svlv[g]),
            .o_pkt   (w_spkt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_occ <= '0;
        else        r_occ <= OCC_W'(popcount_occ(w_nvld32));
    end

`ifdef FETCH_PIPE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_svld[DEPTH-1] && !out_ready_i && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_i && (|w_svld) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

    assign in_ready_o  = w_ready;
    assign out_valid_o = w_svlv[DEPTH-1] & {LANES{~flush_i}};
    assign out_pkt_o   = w_spkt[DEPTH-1];
    assign occupancy_o = r_occ;

endmodule
